// File: rtl/vga_timing_controller.sv
// VGA timing controller: generates 640x480@60Hz raster timing from the pixel
// clock, publishes the current pixel coordinates to the pattern source, and
// registers the returned colour with hsync/vsync so that both leave on the
// same clock edge towards the connector.
module vga_timing_controller #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk_25,
    input  logic        resetN,
    input  logic [3:0]  red_in,
    input  logic [3:0]  green_in,
    input  logic [3:0]  blue_in,
    output logic [31:0] pxl_x,
    output logic [31:0] pxl_y,
    output logic        visible,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap;
    logic          v_wrap;
    logic          hs_next;
    logic          vs_next;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    // Sync pulses are active low; the vertical pulse covers whole lines.
    assign hs_next = !((h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END));
    assign vs_next = !((v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END));

    assign visible = (h_cnt < H_VIS_END) && (v_cnt < V_VIS_END);
    assign pxl_x   = 32'(h_cnt);
    assign pxl_y   = 32'(v_cnt);

    // Raster counters: h_cnt runs every clock, v_cnt advances on line wrap.
    always_ff @(posedge clk_25 or negedge resetN) begin
        if (!resetN) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            // NOTE: non-blocking assignments keep every register in this block
            // reading the pre-edge values, so the wrap decision and the
            // increment see the same counter state.
            h_cnt <= '0;
            v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Output stage: colour, syncs and frame marker for the current coordinate
    // are registered together so they reach the pins with no relative skew.
    always_ff @(posedge clk_25 or negedge resetN) begin
        if (!resetN) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            vga_r       <= visible ? red_in   : 4'h0;
            vga_g       <= visible ? green_in : 4'h0;
            vga_b       <= visible ? blue_in  : 4'h0;
            vga_hs      <= hs_next;
            vga_vs      <= vs_next;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

endmodule

// File: tb/tb_vga_timing_controller.sv
// Testbench for vga_timing_controller. A full-size instance covers reset,
// horizontal timing and alignment; a shrunken instance covers vertical timing
// and frame wrap in a few hundred clocks.
module tb_vga_timing_controller;

    typedef struct {
        int ha, hfp, hs, hbp;
        int va, vfp, vs, vbp;
    } timing_t;

    typedef struct {
        logic [3:0] r, g, b;
        logic       hs, vs, fs;
    } out_t;

    typedef struct {
        int         h;
        logic [3:0] r, g, b;
        logic [3:0] er, eg, eb;
        logic       ehs;
    } vec_t;

    localparam timing_t BIG   = '{640, 16, 96, 48, 480, 10, 2, 33};
    localparam timing_t SMALL = '{16, 4, 6, 4, 12, 2, 2, 3};
    localparam out_t    RST_OUT = '{4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0};

    logic clk_25 = 1'b0;
    logic resetN;
    logic [3:0] r_drv, g_drv, b_drv;
    logic align_mode;

    logic [31:0] b_pxl_x, b_pxl_y, s_pxl_x, s_pxl_y;
    logic        b_visible, s_visible;
    logic [3:0]  b_r, b_g, b_b, s_r, s_g, s_b;
    logic        b_hs, b_vs, b_fs, s_hs, s_vs, s_fs;
    logic [3:0]  b_red_in;

    int checks = 0;
    int errors = 0;
    int t;

    always #20 clk_25 = ~clk_25;

    // The full-size instance can be fed a pattern whose red follows pxl_x.
    assign b_red_in = align_mode ? b_pxl_x[3:0] : r_drv;

    vga_timing_controller dut_big (
        .clk_25(clk_25), .resetN(resetN),
        .red_in(b_red_in), .green_in(g_drv), .blue_in(b_drv),
        .pxl_x(b_pxl_x), .pxl_y(b_pxl_y), .visible(b_visible),
        .vga_r(b_r), .vga_g(b_g), .vga_b(b_b),
        .vga_hs(b_hs), .vga_vs(b_vs), .frame_start(b_fs)
    );

    vga_timing_controller #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut_small (
        .clk_25(clk_25), .resetN(resetN),
        .red_in(r_drv), .green_in(g_drv), .blue_in(b_drv),
        .pxl_x(s_pxl_x), .pxl_y(s_pxl_y), .visible(s_visible),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
        .vga_hs(s_hs), .vga_vs(s_vs), .frame_start(s_fs)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d)", name, act, exp, t);
        end
    endtask

    function automatic int h_total(timing_t p);
        return p.ha + p.hfp + p.hs + p.hbp;
    endfunction

    function automatic int v_total(timing_t p);
        return p.va + p.vfp + p.vs + p.vbp;
    endfunction

    // Raster position after t clocks of free running from (0,0).
    function automatic int pos_x(int tt, timing_t p);
        return tt % h_total(p);
    endfunction

    function automatic int pos_y(int tt, timing_t p);
        return (tt / h_total(p)) % v_total(p);
    endfunction

    function automatic logic is_visible(int tt, timing_t p);
        return (pos_x(tt, p) < p.ha) && (pos_y(tt, p) < p.va);
    endfunction

    // Pin values one clock after raster position tt was presented with colour r/g/b.
    function automatic out_t model(int tt, timing_t p, logic [3:0] r, logic [3:0] g, logic [3:0] b);
        out_t o;
        int x = pos_x(tt, p);
        int y = pos_y(tt, p);
        logic vis = is_visible(tt, p);
        o.r  = vis ? r : 4'h0;
        o.g  = vis ? g : 4'h0;
        o.b  = vis ? b : 4'h0;
        o.hs = !(x >= p.ha + p.hfp && x < p.ha + p.hfp + p.hs);
        o.vs = !(y >= p.va + p.vfp && y < p.va + p.vfp + p.vs);
        o.fs = (x == 0) && (y == 0);
        return o;
    endfunction

    task automatic check_big(input string tag, input out_t e);
        check({tag, " big vga_r"}, 32'(b_r), 32'(e.r));
        check({tag, " big vga_g"}, 32'(b_g), 32'(e.g));
        check({tag, " big vga_b"}, 32'(b_b), 32'(e.b));
        check({tag, " big vga_hs"}, 32'(b_hs), 32'(e.hs));
        check({tag, " big vga_vs"}, 32'(b_vs), 32'(e.vs));
        check({tag, " big frame_start"}, 32'(b_fs), 32'(e.fs));
    endtask

    task automatic check_small(input string tag, input out_t e);
        check({tag, " small vga_r"}, 32'(s_r), 32'(e.r));
        check({tag, " small vga_g"}, 32'(s_g), 32'(e.g));
        check({tag, " small vga_b"}, 32'(s_b), 32'(e.b));
        check({tag, " small vga_hs"}, 32'(s_hs), 32'(e.hs));
        check({tag, " small vga_vs"}, 32'(s_vs), 32'(e.vs));
        check({tag, " small frame_start"}, 32'(s_fs), 32'(e.fs));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " big pxl_x"}, b_pxl_x, 32'd0);
        check({tag, " big pxl_y"}, b_pxl_y, 32'd0);
        check({tag, " small pxl_x"}, s_pxl_x, 32'd0);
        check({tag, " small pxl_y"}, s_pxl_y, 32'd0);
        check_big(tag, RST_OUT);
        check_small(tag, RST_OUT);
    endtask

    // Waits (at negedges) until the big instance shows pxl_x == h.
    task automatic wait_x(input int h);
        for (int i = 0; i < 2000; i++) begin
            if (b_pxl_x == 32'(h)) return;
            @(negedge clk_25);
        end
        checks++;
        errors++;
        $display("FAIL wait_x timeout: pxl_x never reached %0d", h);
    endtask

    // Free-running random-colour run compared cycle by cycle against the model.
    // Entered at a negedge right after reset release (t = 0).
    task automatic run_random(input int n, input logic align);
        out_t e_big   = RST_OUT;
        out_t e_small = RST_OUT;
        int   fs_big = 0, fs_small = 0;
        int   hs_run = 0, hs_max = 0, vs_run = 0, vs_max = 0;
        logic [3:0] red_big;
        align_mode = align;
        for (int k = 0; k < n; k++) begin
            check("rand big pxl_x", b_pxl_x, 32'(pos_x(t, BIG)));
            check("rand big pxl_y", b_pxl_y, 32'(pos_y(t, BIG)));
            check("rand big visible", 32'(b_visible), 32'(is_visible(t, BIG)));
            check("rand small pxl_x", s_pxl_x, 32'(pos_x(t, SMALL)));
            check("rand small pxl_y", s_pxl_y, 32'(pos_y(t, SMALL)));
            check("rand small visible", 32'(s_visible), 32'(is_visible(t, SMALL)));
            check_big("rand", e_big);
            check_small("rand", e_small);

            if (b_fs) fs_big++;
            if (s_fs) fs_small++;
            if (!b_hs) hs_run++;
            else begin
                if (hs_run > hs_max) hs_max = hs_run;
                hs_run = 0;
            end
            if (!s_vs) vs_run++;
            else begin
                if (vs_run > vs_max) vs_max = vs_run;
                vs_run = 0;
            end

            r_drv = 4'($urandom);
            g_drv = 4'($urandom);
            b_drv = 4'($urandom);
            red_big = align ? 4'(pos_x(t, BIG)) : r_drv;
            e_big   = model(t, BIG, red_big, g_drv, b_drv);
            e_small = model(t, SMALL, r_drv, g_drv, b_drv);

            @(posedge clk_25);
            t++;
            @(negedge clk_25);
        end
        check("big hsync low width", 32'(hs_max), 32'(BIG.hs));
        check("small vsync low width", 32'(vs_max), 32'(SMALL.vs * h_total(SMALL)));
        check("big frame_start count", 32'(fs_big), 32'd1);
        check("small frame_start count", 32'(fs_small),
              32'((n - 2) / (h_total(SMALL) * v_total(SMALL)) + 1));
    endtask

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[9];
        vecs[0] = '{0,   4'hA, 4'h5, 4'h3, 4'hA, 4'h5, 4'h3, 1'b1};
        vecs[1] = '{1,   4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1};
        vecs[2] = '{639, 4'h1, 4'h2, 4'h3, 4'h1, 4'h2, 4'h3, 1'b1};
        vecs[3] = '{640, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1};
        vecs[4] = '{655, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1};
        vecs[5] = '{656, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
        vecs[6] = '{751, 4'h7, 4'h7, 4'h7, 4'h0, 4'h0, 4'h0, 1'b0};
        vecs[7] = '{752, 4'h7, 4'h7, 4'h7, 4'h0, 4'h0, 4'h0, 1'b1};
        vecs[8] = '{799, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 1'b1};

        t = 0;
        align_mode = 1'b0;
        resetN = 1'b0;
        r_drv = 4'hF;
        g_drv = 4'hF;
        b_drv = 4'hF;

        // Reset held across 10 clocks with colour inputs high.
        repeat (10) @(posedge clk_25);
        @(negedge clk_25);
        check_reset_state("reset");

        // Release away from the edge; counting starts on the next edge.
        resetN = 1'b1;
        @(negedge clk_25);
        check("count pxl_x 1", b_pxl_x, 32'd1);
        check("first frame_start", 32'(b_fs), 32'd1);
        @(negedge clk_25);
        check("count pxl_x 2", b_pxl_x, 32'd2);
        check("frame_start single", 32'(b_fs), 32'd0);
        @(negedge clk_25);
        check("count pxl_x 3", b_pxl_x, 32'd3);

        // Horizontal boundaries on line 1 of the full-size raster.
        foreach (vecs[i]) begin
            wait_x(vecs[i].h);
            r_drv = vecs[i].r;
            g_drv = vecs[i].g;
            b_drv = vecs[i].b;
            @(posedge clk_25);
            @(negedge clk_25);
            check($sformatf("vec x=%0d vga_r", vecs[i].h), 32'(b_r), 32'(vecs[i].er));
            check($sformatf("vec x=%0d vga_g", vecs[i].h), 32'(b_g), 32'(vecs[i].eg));
            check($sformatf("vec x=%0d vga_b", vecs[i].h), 32'(b_b), 32'(vecs[i].eb));
            check($sformatf("vec x=%0d vga_hs", vecs[i].h), 32'(b_hs), 32'(vecs[i].ehs));
            check($sformatf("vec x=%0d vga_vs", vecs[i].h), 32'(b_vs), 32'd1);
        end
        check("line wrap pxl_x", b_pxl_x, 32'd0);
        check("line wrap pxl_y", b_pxl_y, 32'd2);

        // Mid-line reset must clear everything without a clock edge.
        resetN = 1'b0;
        #1;
        check_reset_state("async reset 1");
        repeat (3) @(posedge clk_25);
        @(negedge clk_25);
        resetN = 1'b1;
        t = 0;
        run_random(1300, 1'b0);

        // Second mid-frame reset, then an aligned pattern run.
        check("pre-reset pxl_x nonzero", 32'(b_pxl_x != 0), 32'd1);
        resetN = 1'b0;
        #1;
        check_reset_state("async reset 2");
        repeat (2) @(posedge clk_25);
        @(negedge clk_25);
        resetN = 1'b1;
        t = 0;
        run_random(1300, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_controller.md
Name: vga_timing_controller

Overview:
- Display-side end of the pixel interface. Generates 640x480@60Hz VGA timing from the 25 MHz pixel clock.
- Publishes the current pixel coordinates (pxl_x, pxl_y) to pattern/drawing blocks, which return 4-bit RGB combinationally.
- Registers the returned colour together with the sync signals, blanks colour outside the active area, and drives the DE10-Lite VGA connector pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- clk_25 in 1 pixel clock, 25 MHz
- resetN in 1 asynchronous active-low reset
- red_in in 4 colour returned by pattern source for current pxl_x/pxl_y
- green_in in 4 colour returned by pattern source
- blue_in in 4 colour returned by pattern source
- pxl_x out 32 current horizontal counter, 0..H_TOTAL-1
- pxl_y out 32 current vertical counter, 0..V_TOTAL-1
- visible out 1 high when pxl_x<H_ACTIVE and pxl_y<V_ACTIVE (combinational from counters)
- vga_r out 4 registered red to connector
- vga_g out 4 registered green to connector
- vga_b out 4 registered blue to connector
- vga_hs out 1 registered hsync, active low
- vga_vs out 1 registered vsync, active low
- frame_start out 1 registered one-cycle pulse, first output cycle of each frame

Behaviour:
- Clock and reset: single clock domain clk_25. resetN asynchronous, active low.
- Derived constants: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset values: h_cnt=0, v_cnt=0, so pxl_x=0 and pxl_y=0. vga_r/g/b=0, vga_hs=1, vga_vs=1, frame_start=0.
- Horizontal counter: h_cnt increments every clock. At H_TOTAL-1 it wraps to 0.
- Vertical counter: v_cnt increments only on the h_cnt wrap cycle. When h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1 (simultaneous wrap), both go to 0.
- Coordinate outputs: pxl_x=h_cnt and pxl_y=v_cnt, zero-extended to 32 bits. Both are direct register outputs.
- hs_next: low iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
- vs_next: low iff V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491, for all h_cnt on those lines.
- Output stage (1 register, latency 1 clock):
  - vga_hs<=hs_next, vga_vs<=vs_next.
  - vga_r/g/b <= visible ? {red,green,blue}_in : 0.
  - frame_start <= (h_cnt==0 && v_cnt==0).
  - Sync and colour for a given pxl_x/pxl_y therefore appear together on the same clock edge, exactly one cycle after the coordinates.
- Blanking: colour is forced to 0 in all porch and sync regions, whatever the inputs are.
- Ports are not sampled outside the output stage. There is no handshake: the pattern source must settle within one clock.
- Reset mid-frame: counters and outputs return to their reset values immediately (asynchronous). Counting restarts at (0,0) on the first clock edge after resetN deasserts. frame_start pulses one cycle after that first edge.
- Frame period: 800*525 = 420000 clocks. vga_hs has 525 low pulses per frame, each 96 clocks long. vga_vs is low for 1600 consecutive clocks per frame.

Test Plan:
- Reset: hold resetN=0 across 10 clocks -> pxl_x=0, pxl_y=0, vga_hs=1, vga_vs=1, vga_r/g/b=0, frame_start=0. Release -> pxl_x counts 1,2,3 on the following edges.
- Horizontal timing: run one line -> pxl_x wraps 799->0 and pxl_y increments by 1. vga_hs goes low one clock after pxl_x=656, stays low exactly 96 clocks, and returns high one clock after pxl_x=752.
- Vertical timing and frame: run 420000 clocks -> pxl_y wraps 524->0 together with the pxl_x 799->0 wrap. vga_vs is low for 1600 clocks beginning one clock after (0,490). frame_start is high for exactly 1 clock per frame, one clock after (0,0).
- Blanking: drive red_in=green_in=blue_in=4'hF constantly -> vga_r/g/b=F exactly one clock after pxl_x in 0..639 with pxl_y<480. Output is 0 one clock after pxl_x=640..799, and 0 for all of lines 480..524.
- Alignment: connect a pattern source whose red=pxl_x[3:0] -> vga_r equals (previous pxl_x)[3:0] on every visible cycle, with no skew against vga_hs.
- Reset mid-operation: assert resetN=0 at pxl_x=300, pxl_y=200 -> all outputs return to reset values without waiting for a clock edge. After release, the frame restarts at (0,0) and a new frame_start pulse follows.
